// File: rtl/adder_pkg.sv
// Shared types and constants for the adders library.
// Holds the XOR half-adder sum function that the serial adder slices reuse.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } adder_state_t;

    // Half-adder sum: the library's basic XOR cell.
    function automatic logic xor2(input logic x, input logic y);
        return x ^ y;
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational full-adder slice for the bit-serial adder.
// The sum is two cascaded XOR cells; the carry uses the propagate term.
module fa_bit
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    always_comb begin
        p  = xor2(a, b);
        s  = xor2(p, ci);
        co = (a & b) | (ci & p);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice reused over WIDTH clocks, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    adder_state_t     state;
    adder_state_t     state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cout_r;
    logic             last_step;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_r;
`endif

    fa_bit u_fa_bit (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands are captured only on an accepted start; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        cout_r <= fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the final step the carry FF holds the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (last_step) begin
            ovf_r <= carry ^ fa_co;
        end
    end

    assign ovf = ovf_r;
`endif

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference.
// Covers SERIAL_ADDER_OVF_EN when the macro is defined for the build.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .cin   (op_cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the captured operands.
    task automatic check_result(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        int unsigned total;
        int          sa;
        int          sb;
        int          ss;
        total = int'(xa) + int'(xb) + int'(xc);
        check("sum", 32'(sum), total % 256);
        check("cout", 32'(cout), total / 256);
`ifdef SERIAL_ADDER_OVF_EN
        sa = (xa >= 8'd128) ? int'(xa) - 256 : int'(xa);
        sb = (xb >= 8'd128) ? int'(xb) - 256 : int'(xb);
        ss = sa + sb + int'(xc);
        check("ovf", 32'(ovf), (ss > 127 || ss < -128) ? 1 : 0);
`else
        sa = 0;
        sb = 0;
        ss = sa + sb;
`endif
    endtask

    // Full transaction; operands are scrambled while busy to prove capture.
    task automatic add_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        @(negedge clk);
        op_a   = xa;
        op_b   = xb;
        op_cin = xc;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            check("busy_shift", 32'(busy), 1);
            check("done_shift", 32'(done), 0);
            op_a   = W'($urandom);
            op_b   = W'($urandom);
            op_cin = 1'($urandom);
            @(negedge clk);
        end
        check("busy_done", 32'(busy), 0);
        check("done_pulse", 32'(done), 1);
        check_result(xa, xb, xc);
        @(negedge clk);
        check("done_end", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check_result(xa, xb, xc);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst    = 1'b1;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        rst = 1'b0;

        add_op(8'h5A, 8'h3C, 1'b0);
        add_op(8'hFF, 8'h01, 1'b0);
        add_op(8'hFF, 8'hFF, 1'b1);
        add_op(8'h7F, 8'h01, 1'b0);
        add_op(8'h80, 8'h80, 1'b0);

        // start held high throughout; a cleared mid-operation
        @(negedge clk);
        op_a   = 8'h12;
        op_b   = 8'h34;
        op_cin = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(W); i++) begin
            check("hold_busy", 32'(busy), 1);
            if (i == 3) op_a = 8'h00;
            @(negedge clk);
        end
        check("hold_done", 32'(done), 1);
        check_result(8'h12, 8'h34, 1'b1);
        op_a   = 8'h10;
        op_b   = 8'h20;
        op_cin = 1'b0;
        @(negedge clk);
        check("hold_ign_busy", 32'(busy), 0);
        check("hold_ign_done", 32'(done), 0);
        check("hold_sum_kept", 32'(sum), 32'h47);
        @(negedge clk);
        check("hold_accept", 32'(busy), 1);
        start = 1'b0;
        repeat (W) @(negedge clk);
        check("hold2_done", 32'(done), 1);
        check_result(8'h10, 8'h20, 1'b0);
        @(negedge clk);

        // asynchronous reset part-way through
        @(negedge clk);
        op_a   = 8'hFF;
        op_b   = 8'hFF;
        op_cin = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_sum", 32'(sum), 0);
        check("arst_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        add_op(8'h01, 8'h02, 1'b0);

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            add_op(ra, rb, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder, the stage directly downstream of the combinational XOR (half-adder sum) function in the adders library.
- Computes each sum bit with that XOR function plus a carry flip-flop, one bit per clock, LSB first.
- Trades area for latency: one full-adder slice reused across WIDTH cycles.
- Load/start/done handshake so a controller or testbench can issue back-to-back additions.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk    input   1      single clock; all state changes on rising edge
- rst    input   1      reset, asynchronous, active-high
- start  input   1      request an addition; sampled only in IDLE
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the accepted start edge
- busy   output  1      high while state is SHIFT
- done   output  1      one-cycle pulse in state DONE
- sum    output  WIDTH  result; valid from done-high until the next accepted start
- cout   output  1      final carry; same validity as sum

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry FF and bit counter all cleared.
- Reset mid-operation aborts the addition; no partial result is kept. First start after rst deasserts is accepted normally.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on an edge where start=1.
  - SHIFT -> DONE on the edge ending the WIDTH-th bit step.
  - DONE -> IDLE unconditionally on the next edge.
- Accepting start (edge E, in IDLE):
  - Load the A and B shift registers with a and b; carry FF <= cin; count <= 0.
- Each SHIFT cycle (one bit step per edge):
  - s = A[0] ^ B[0] ^ carry
  - carry <= (A[0]&B[0]) | (carry&(A[0]^B[0]))
  - Sum register shifts right with s inserted at the MSB; A and B shift right; count increments.
- Latency:
  - busy=1 in cycles E..E+WIDTH-1.
  - State is DONE after edge E+WIDTH; done=1 during the following cycle only.
  - IDLE again after edge E+WIDTH+1, so the next start is accepted at earliest on edge E+WIDTH+2.
- Outputs:
  - sum is the sum shift register; it shows intermediate bits during SHIFT and holds its value in DONE and IDLE.
  - cout is loaded from the carry FF on the SHIFT->DONE edge.
- start while in SHIFT or DONE is ignored; a, b and cin changes after capture have no effect.
- Width rules:
  - Unsigned addition modulo 2^WIDTH; carry beyond the MSB appears only on cout.
  - Counter width is $clog2(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - Registered on the SHIFT->DONE edge with the same validity as cout; reset value 0.
- Undefined: port and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package adder_pkg holds:
  - state typedef (IDLE, SHIFT, DONE; 2-bit encoding);
  - default width constant ADDER_WIDTH_DEFAULT=8.
- One sub-module, fa_bit: combinational full-adder slice (a, b, ci -> s, co). Its sum is built from two instances of the existing XOR function.
- serial_adder instantiates fa_bit once; the FSM, counter and shift registers stay in the top level.

Test Plan (WIDTH=8):
- Basic add: a=8'h5A, b=8'h3C, cin=0, start pulsed at edge E.
  - busy high for cycles E..E+7; done high for exactly one cycle after edge E+8.
  - sum=8'h96, cout=0; with the macro, ovf=1.
- Carry wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- Max with carry-in: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start ignored: start held high through SHIFT, and a changed to 8'h00 mid-operation.
  - The single result equals the captured operands.
  - Second addition is accepted only at edge E+10.
- Reset mid-operation: assert rst at cycle E+4.
  - busy, done, sum and cout read 0 immediately (asynchronous).
  - After release, a=8'h01, b=8'h02 -> sum=8'h03, cout=0.
- Overflow (macro defined): a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
